// File: rtl/microbio2_pkg.sv
// Shared opcodes, FSM state encoding and branch helper for the microbio2 core.
// The optional single-step feature is enabled with `define MICROBIO2_STEP_EN.
package microbio2_pkg;

    localparam logic [2:0] OP_WAIT = 3'b000;
    localparam logic [2:0] OP_HALT = 3'b001;
    localparam logic [2:0] OP_LEDS = 3'b010;
    localparam logic [2:0] OP_JP   = 3'b011;
    localparam logic [2:0] OP_LDC  = 3'b100;
    localparam logic [2:0] OP_DJNZ = 3'b101;
    localparam logic [2:0] OP_ADDL = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_WAITING,
        ST_HALTED
    } state_t;

    // A taken branch reloads pc, so the next ROM word needs a fresh access cycle.
    function automatic logic branch_taken(input logic [2:0] co, input logic lc_next_nz);
        return (co == OP_JP) || ((co == OP_DJNZ) && lc_next_nz);
    endfunction

endpackage

// File: rtl/microbio2_timer.sv
// Wait-tick generator: one-cycle tick every WAIT_DELAY cycles counted from clr.
// Part of the microbio2 core (see microbio2.sv for MICROBIO2_STEP_EN).
module microbio2_timer #(
    parameter int WAIT_DELAY = 2400000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int CW = (WAIT_DELAY > 1) ? $clog2(WAIT_DELAY) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_DELAY - 1);

    logic [CW-1:0] cnt;

    // Wrapping at LAST rather than free-running keeps successive ticks exactly WAIT_DELAY apart.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/microbio2.sv
// microbio2: ROM-fed mini processor driving a LED register, with WAIT, DJNZ, ADDL and resume.
// Define MICROBIO2_STEP_EN to add step_mode/step inputs for single-instruction stepping.
module microbio2
    import microbio2_pkg::*;
#(
    parameter int AW         = 6,
    parameter int LED_W      = 4,
    parameter int WAIT_DELAY = 2400000
) (
    input  logic             clk,
    input  logic             rstn,
    output logic [AW-1:0]    rom_addr,
    input  logic [AW+2:0]    rom_data,
    input  logic             resume,
`ifdef MICROBIO2_STEP_EN
    input  logic             step_mode,
    input  logic             step,
`endif
    output logic [LED_W-1:0] leds,
    output logic             stop
);

    localparam int IW = 3 + AW;

    state_t state;
    state_t state_nxt;

    logic [AW-1:0] pc;
    logic [IW-1:0] ir;
    logic [AW-1:0] lc;
    logic [AW-1:0] tick_cnt;

    logic [2:0]    co;
    logic [AW-1:0] dat;
    logic [AW-1:0] lc_dec;
    logic          lc_dec_nz;

    logic fetch_go;
    logic exec_en;
    logic timer_clr;
    logic tick;
    logic tick_adv;
    logic wait_done;
    logic step_ok;

    assign co        = ir[IW-1:AW];
    assign dat       = ir[AW-1:0];
    assign lc_dec    = lc - AW'(1);
    assign lc_dec_nz = (lc_dec != '0);
    assign rom_addr  = pc;

`ifdef MICROBIO2_STEP_EN
    logic step_armed;

    // A pulse arriving outside FETCH is remembered so exactly one instruction runs per pulse.
    always_ff @(posedge clk) begin
        if (!rstn || !step_mode) begin
            step_armed <= 1'b0;
        end else if (fetch_go) begin
            step_armed <= step && step_armed;
        end else if (step) begin
            step_armed <= 1'b1;
        end
    end

    assign step_ok = !step_mode || step || step_armed;
`else
    assign step_ok = 1'b1;
`endif

    microbio2_timer #(
        .WAIT_DELAY(WAIT_DELAY)
    ) u_timer (
        .clk  (clk),
        .rstn (rstn),
        .clr  (timer_clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:    state_nxt = ST_FETCH;
            ST_FETCH:   if (fetch_go) state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (co == OP_HALT) begin
                    state_nxt = ST_HALTED;
                end else if (branch_taken(co, lc_dec_nz)) begin
                    state_nxt = ST_INIT;
                end else if (timer_clr) begin
                    state_nxt = ST_WAITING;
                end else begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_WAITING: if (wait_done) state_nxt = ST_FETCH;
            ST_HALTED:  if (resume) state_nxt = ST_FETCH;
            default:    state_nxt = ST_INIT;
        endcase
    end

    // WAIT 0 never enters WAITING, so it costs the same as a NOP.
    always_comb begin
        fetch_go  = (state == ST_FETCH) && step_ok;
        exec_en   = (state == ST_EXEC);
        timer_clr = exec_en && (co == OP_WAIT) && (dat != '0);
        tick_adv  = (state == ST_WAITING) && tick;
        wait_done = tick_adv && ((tick_cnt + AW'(1)) == dat);
        stop      = (state == ST_HALTED);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc <= '0;
            ir <= '0;
        end else if (fetch_go) begin
            ir <= rom_data;
            pc <= pc + AW'(1);
        end else if (exec_en && branch_taken(co, lc_dec_nz)) begin
            pc <= dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lc <= '0;
        end else if (exec_en && (co == OP_LDC)) begin
            lc <= dat;
        end else if (exec_en && (co == OP_DJNZ)) begin
            lc <= lc_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            leds <= '0;
        end else if (exec_en && (co == OP_LEDS)) begin
            leds <= dat[LED_W-1:0];
        end else if (exec_en && (co == OP_ADDL)) begin
            leds <= leds + dat[LED_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || timer_clr) begin
            tick_cnt <= '0;
        end else if (tick_adv) begin
            tick_cnt <= tick_cnt + AW'(1);
        end
    end

endmodule

// File: tb/tb_microbio2.sv
// Scoreboard bench for microbio2: expected LED changes (value, cycle) are queued per program
// and matched against changes observed on the leds output.
module tb_microbio2;
    import microbio2_pkg::*;

    localparam int AW    = 6;
    localparam int LED_W = 4;
    localparam int WD    = 4;
    localparam int IW    = 3 + AW;

    typedef struct {
        logic [LED_W-1:0] val;
        int               cyc;
    } ev_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             resume = 1'b0;
    logic [IW-1:0]    rom_data;
    logic [AW-1:0]    rom_addr;
    logic [LED_W-1:0] leds;
    logic             stop;
`ifdef MICROBIO2_STEP_EN
    logic             step_mode = 1'b0;
    logic             step = 1'b0;
`endif

    logic [IW-1:0]    rom [0:63];
    int               vectors = 0;
    int               miscompares = 0;
    int               cyc = 0;
    ev_t              exp_q[$];
    ev_t              obs_q[$];
    logic [LED_W-1:0] prev_leds;
    bit               mon_en = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(posedge clk) begin
        if (!rstn) cyc = 0;
        else       cyc = cyc + 1;
    end

    // Every change on leds is logged with the cycle number since reset release.
    always @(negedge clk) begin
        if (mon_en && (leds !== prev_leds)) obs_q.push_back('{leds, cyc});
        prev_leds = leds;
    end

    microbio2 #(
        .AW(AW),
        .LED_W(LED_W),
        .WAIT_DELAY(WD)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .resume   (resume),
`ifdef MICROBIO2_STEP_EN
        .step_mode(step_mode),
        .step     (step),
`endif
        .leds     (leds),
        .stop     (stop)
    );

    function automatic logic [IW-1:0] ins(input logic [2:0] op, input logic [AW-1:0] d);
        return {op, d};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = ins(OP_NOP, 6'd0);
    endtask

    task automatic applyStimulus();
        rstn   = 1'b0;
        resume = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        obs_q.delete();
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic run_to(input int n);
        repeat (n - cyc) @(negedge clk);
    endtask

    task automatic test_reset();
        clear_rom();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (leds !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_leds: got %h want 0", leds); end
        vectors++;
        if (stop !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stop: got %b want 0", stop); end
        vectors++;
        if (rom_addr !== 6'd0) begin miscompares++; $display("[TB] FAIL reset_addr: got %0d want 0", rom_addr); end
        vectors++;
        if (dut.lc !== 6'd0) begin miscompares++; $display("[TB] FAIL reset_lc: got %0d want 0", dut.lc); end
        rstn = 1'b1;
        mon_en = 1'b1;
        run_to(1);
        vectors++;
        if (rom_addr !== 6'd0) begin miscompares++; $display("[TB] FAIL fetch_addr: got %0d want 0", rom_addr); end
        run_to(2);
        vectors++;
        if (rom_addr !== 6'd1) begin miscompares++; $display("[TB] FAIL exec_addr: got %0d want 1", rom_addr); end
    endtask

    task automatic test_leds_halt();
        ev_t e, o;
        clear_rom();
        rom[0] = ins(OP_LEDS, 6'h0A);
        rom[1] = ins(OP_HALT, 6'd0);
        applyStimulus();
        exp_q.push_back('{4'hA, 3});
        run_to(4);
        vectors++;
        if (stop !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_stop4: got %b want 0", stop); end
        run_to(5);
        vectors++;
        if (stop !== 1'b1) begin miscompares++; $display("[TB] FAIL halt_stop5: got %b want 1", stop); end
        run_to(12);
        vectors++;
        if (stop !== 1'b1) begin miscompares++; $display("[TB] FAIL halt_hold: got %b want 1", stop); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("[TB] FAIL leds_halt_event: got none want %h@%0d", e.val, e.cyc); end
            else begin
                o = obs_q.pop_front();
                if (o.val !== e.val || o.cyc != e.cyc) begin miscompares++; $display("[TB] FAIL leds_halt_event: got %h@%0d want %h@%0d", o.val, o.cyc, e.val, e.cyc); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL leds_halt_extra: got %0d events want 0", obs_q.size()); end
    endtask

    task automatic test_wait();
        ev_t e, o;
        for (int v = 0; v < 2; v++) begin
            clear_rom();
            rom[0] = ins(OP_WAIT, (v == 0) ? 6'd3 : 6'd0);
            rom[1] = ins(OP_LEDS, 6'h05);
            rom[2] = ins(OP_HALT, 6'd0);
            applyStimulus();
            exp_q.push_back('{4'h5, (v == 0) ? 17 : 5});
            run_to((v == 0) ? 18 : 6);
            vectors++;
            if (stop !== 1'b0) begin miscompares++; $display("[TB] FAIL wait%0d_run: stop got %b want 0", v, stop); end
            run_to((v == 0) ? 19 : 7);
            vectors++;
            if (stop !== 1'b1) begin miscompares++; $display("[TB] FAIL wait%0d_halt: stop got %b want 1", v, stop); end
            run_to(24);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (obs_q.size() == 0) begin miscompares++; $display("[TB] FAIL wait%0d_event: got none want %h@%0d", v, e.val, e.cyc); end
                else begin
                    o = obs_q.pop_front();
                    if (o.val !== e.val || o.cyc != e.cyc) begin miscompares++; $display("[TB] FAIL wait%0d_event: got %h@%0d want %h@%0d", v, o.val, o.cyc, e.val, e.cyc); end
                end
            end
            vectors++;
            if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL wait%0d_extra: got %0d events want 0", v, obs_q.size()); end
        end
    endtask

    task automatic test_djnz();
        ev_t e, o;
        clear_rom();
        rom[0] = ins(OP_LDC, 6'd3);
        rom[1] = ins(OP_ADDL, 6'd1);
        rom[2] = ins(OP_DJNZ, 6'd1);
        rom[3] = ins(OP_HALT, 6'd0);
        applyStimulus();
        exp_q.push_back('{4'h1, 5});
        exp_q.push_back('{4'h2, 10});
        exp_q.push_back('{4'h3, 15});
        run_to(18);
        vectors++;
        if (stop !== 1'b0) begin miscompares++; $display("[TB] FAIL djnz_run: stop got %b want 0", stop); end
        run_to(19);
        vectors++;
        if (stop !== 1'b1) begin miscompares++; $display("[TB] FAIL djnz_halt: stop got %b want 1", stop); end
        vectors++;
        if (dut.lc !== 6'd0) begin miscompares++; $display("[TB] FAIL djnz_lc: got %0d want 0", dut.lc); end
        // DJNZ with lc = 0 wraps to all ones and branches.
        clear_rom();
        rom[0] = ins(OP_DJNZ, 6'd2);
        rom[1] = ins(OP_HALT, 6'd0);
        rom[2] = ins(OP_LEDS, 6'd6);
        rom[3] = ins(OP_HALT, 6'd0);
        obs_q.delete();
        applyStimulus();
        exp_q.push_back('{4'h1, 5});
        exp_q.push_back('{4'h2, 10});
        exp_q.push_back('{4'h3, 15});
        exp_q.delete();
        exp_q.push_back('{4'h6, 6});
        run_to(8);
        vectors++;
        if (stop !== 1'b1) begin miscompares++; $display("[TB] FAIL djnz0_halt: stop got %b want 1", stop); end
        vectors++;
        if (dut.lc !== 6'd63) begin miscompares++; $display("[TB] FAIL djnz0_lc: got %0d want 63", dut.lc); end
        run_to(12);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("[TB] FAIL djnz_event: got none want %h@%0d", e.val, e.cyc); end
            else begin
                o = obs_q.pop_front();
                if (o.val !== e.val || o.cyc != e.cyc) begin miscompares++; $display("[TB] FAIL djnz_event: got %h@%0d want %h@%0d", o.val, o.cyc, e.val, e.cyc); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL djnz_extra: got %0d events want 0", obs_q.size()); end
    endtask

    task automatic test_djnz_loop_events();
        ev_t e, o;
        // Re-run the counted loop purely for its LED sequence.
        clear_rom();
        rom[0] = ins(OP_LDC, 6'd3);
        rom[1] = ins(OP_ADDL, 6'd1);
        rom[2] = ins(OP_DJNZ, 6'd1);
        rom[3] = ins(OP_HALT, 6'd0);
        applyStimulus();
        exp_q.push_back('{4'h1, 5});
        exp_q.push_back('{4'h2, 10});
        exp_q.push_back('{4'h3, 15});
        run_to(24);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("[TB] FAIL loop_event: got none want %h@%0d", e.val, e.cyc); end
            else begin
                o = obs_q.pop_front();
                if (o.val !== e.val || o.cyc != e.cyc) begin miscompares++; $display("[TB] FAIL loop_event: got %h@%0d want %h@%0d", o.val, o.cyc, e.val, e.cyc); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL loop_extra: got %0d events want 0", obs_q.size()); end
    endtask

    task automatic test_resume();
        ev_t e, o;
        clear_rom();
        rom[0] = ins(OP_LEDS, 6'd1);
        rom[1] = ins(OP_HALT, 6'd0);
        rom[2] = ins(OP_LEDS, 6'd2);
        rom[3] = ins(OP_HALT, 6'd0);
        applyStimulus();
        exp_q.push_back('{4'h1, 3});
        exp_q.push_back('{4'h2, 11});
        run_to(1); resume = 1'b1;
        run_to(2); resume = 1'b0;
        run_to(4); resume = 1'b1;
        run_to(5); resume = 1'b0;
        run_to(8);
        vectors++;
        if (stop !== 1'b1) begin miscompares++; $display("[TB] FAIL resume_ignored: stop got %b want 1", stop); end
        resume = 1'b1;
        run_to(9); resume = 1'b0;
        run_to(10);
        vectors++;
        if (stop !== 1'b0) begin miscompares++; $display("[TB] FAIL resume_clear: stop got %b want 0", stop); end
        run_to(13);
        vectors++;
        if (stop !== 1'b1) begin miscompares++; $display("[TB] FAIL resume_rehalt: stop got %b want 1", stop); end
        run_to(16);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("[TB] FAIL resume_event: got none want %h@%0d", e.val, e.cyc); end
            else begin
                o = obs_q.pop_front();
                if (o.val !== e.val || o.cyc != e.cyc) begin miscompares++; $display("[TB] FAIL resume_event: got %h@%0d want %h@%0d", o.val, o.cyc, e.val, e.cyc); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL resume_extra: got %0d events want 0", obs_q.size()); end
    endtask

    task automatic test_jump();
        ev_t e, o;
        clear_rom();
        rom[0] = ins(OP_LEDS, 6'h3F);
        rom[1] = ins(OP_JP, 6'd4);
        rom[2] = ins(OP_LEDS, 6'd0);
        rom[3] = ins(OP_HALT, 6'd0);
        rom[4] = ins(OP_ADDL, 6'h13);
        rom[5] = ins(OP_HALT, 6'd0);
        applyStimulus();
        exp_q.push_back('{4'hF, 3});
        exp_q.push_back('{4'h2, 8});
        run_to(5);
        vectors++;
        if (rom_addr !== 6'd4) begin miscompares++; $display("[TB] FAIL jump_addr: got %0d want 4", rom_addr); end
        run_to(9);
        vectors++;
        if (stop !== 1'b0) begin miscompares++; $display("[TB] FAIL jump_run: stop got %b want 0", stop); end
        run_to(10);
        vectors++;
        if (stop !== 1'b1) begin miscompares++; $display("[TB] FAIL jump_halt: stop got %b want 1", stop); end
        run_to(14);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("[TB] FAIL jump_event: got none want %h@%0d", e.val, e.cyc); end
            else begin
                o = obs_q.pop_front();
                if (o.val !== e.val || o.cyc != e.cyc) begin miscompares++; $display("[TB] FAIL jump_event: got %h@%0d want %h@%0d", o.val, o.cyc, e.val, e.cyc); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL jump_extra: got %0d events want 0", obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        clear_rom();
        rom[0] = ins(OP_WAIT, 6'd1);
        rom[1] = ins(OP_ADDL, 6'd1);
        rom[2] = ins(OP_WAIT, 6'd2);
        rom[3] = ins(OP_ADDL, 6'd1);
        rom[4] = ins(OP_HALT, 6'd0);
        applyStimulus();
        exp_q.push_back('{4'h1, 9});
        exp_q.push_back('{4'h2, 21});
        run_to(22);
        vectors++;
        if (stop !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_run: stop got %b want 0", stop); end
        run_to(23);
        vectors++;
        if (stop !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_halt: stop got %b want 1", stop); end
        run_to(28);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("[TB] FAIL b2b_event: got none want %h@%0d", e.val, e.cyc); end
            else begin
                o = obs_q.pop_front();
                if (o.val !== e.val || o.cyc != e.cyc) begin miscompares++; $display("[TB] FAIL b2b_event: got %h@%0d want %h@%0d", o.val, o.cyc, e.val, e.cyc); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL b2b_extra: got %0d events want 0", obs_q.size()); end
    endtask

    task automatic test_reset_mid_wait();
        ev_t e, o;
        clear_rom();
        rom[0] = ins(OP_LEDS, 6'd7);
        rom[1] = ins(OP_WAIT, 6'd3);
        rom[2] = ins(OP_LEDS, 6'd9);
        rom[3] = ins(OP_HALT, 6'd0);
        applyStimulus();
        exp_q.push_back('{4'h7, 3});
        exp_q.push_back('{4'h0, 0});
        exp_q.push_back('{4'h7, 3});
        exp_q.push_back('{4'h9, 19});
        run_to(9);
        rstn = 1'b0;
        @(negedge clk);
        vectors++;
        if (leds !== 4'h0) begin miscompares++; $display("[TB] FAIL midrst_leds: got %h want 0", leds); end
        vectors++;
        if (stop !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_stop: got %b want 0", stop); end
        vectors++;
        if (rom_addr !== 6'd0) begin miscompares++; $display("[TB] FAIL midrst_addr: got %0d want 0", rom_addr); end
        rstn = 1'b1;
        run_to(1);
        vectors++;
        if (rom_addr !== 6'd0) begin miscompares++; $display("[TB] FAIL midrst_fetch: got %0d want 0", rom_addr); end
        run_to(24);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("[TB] FAIL midrst_event: got none want %h@%0d", e.val, e.cyc); end
            else begin
                o = obs_q.pop_front();
                if (o.val !== e.val || o.cyc != e.cyc) begin miscompares++; $display("[TB] FAIL midrst_event: got %h@%0d want %h@%0d", o.val, o.cyc, e.val, e.cyc); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL midrst_extra: got %0d events want 0", obs_q.size()); end
    endtask

`ifdef MICROBIO2_STEP_EN
    task automatic test_step();
        ev_t e, o;
        clear_rom();
        for (int i = 0; i < 8; i++) rom[i] = ins(OP_ADDL, 6'd1);
        step_mode = 1'b1;
        applyStimulus();
        exp_q.push_back('{4'h1, 12});
        exp_q.push_back('{4'h2, 17});
        exp_q.push_back('{4'h3, 22});
        run_to(10);
        vectors++;
        if (rom_addr !== 6'd0) begin miscompares++; $display("[TB] FAIL step_hold: addr got %0d want 0", rom_addr); end
        for (int p = 0; p < 3; p++) begin
            run_to(10 + 5 * p); step = 1'b1;
            run_to(11 + 5 * p); step = 1'b0;
        end
        run_to(30);
        vectors++;
        if (rom_addr !== 6'd3) begin miscompares++; $display("[TB] FAIL step_count: addr got %0d want 3", rom_addr); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("[TB] FAIL step_event: got none want %h@%0d", e.val, e.cyc); end
            else begin
                o = obs_q.pop_front();
                if (o.val !== e.val || o.cyc != e.cyc) begin miscompares++; $display("[TB] FAIL step_event: got %h@%0d want %h@%0d", o.val, o.cyc, e.val, e.cyc); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL step_extra: got %0d events want 0", obs_q.size()); end
        step_mode = 1'b0;
    endtask
`endif

    initial begin
        $display("[TB] microbio2 bench start");
        test_reset();
        test_leds_halt();
        test_wait();
        test_djnz();
        test_djnz_loop_events();
        test_resume();
        test_jump();
        test_back_to_back();
        test_reset_mid_wait();
`ifdef MICROBIO2_STEP_EN
        test_step();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
